// File: rtl/feature_addr_pkg.sv
// Shared constants and FSM encoding for the feature address sequencer.
package feature_addr_pkg;

    localparam int NUM_RECTS  = 3;
    localparam int W_ADDR_DEF = 14;
    localparam int W_CNT_DEF  = 10;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

endpackage

// File: rtl/addr_fork.sv
// Broadcast fork: one source word to NUM_BR valid/ready branches, 0-cycle latency.
// A branch drops valid once it has accepted; the source retires when every branch has taken it.
module addr_fork #(
    parameter int NUM_BR = 3,
    parameter int W_DAT  = 14
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           src_vld,
    input  logic [W_DAT-1:0]               src_dat,
    output logic [NUM_BR-1:0]              br_vld,
    input  logic [NUM_BR-1:0]              br_rdy,
    output logic [NUM_BR-1:0][W_DAT-1:0]   br_dat,
    output logic                           all_accepted
);

    logic [NUM_BR-1:0] sent_q;
    logic [NUM_BR-1:0] sent_d;
    logic [NUM_BR-1:0] fire;

    always_comb begin
        br_vld       = src_vld ? ~sent_q : '0;
        fire         = br_vld & br_rdy;
        all_accepted = src_vld && (&(sent_q | fire));
        // Clearing on the retiring cycle lets the next word go out without a bubble.
        sent_d       = all_accepted ? '0 : (sent_q | fire);
        for (int n = 0; n < NUM_BR; n++) begin
            br_dat[n] = src_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sent_q <= '0;
        end else begin
            sent_q <= sent_d;
        end
    end

endmodule

// File: rtl/feature_addr_gen.sv
// Walks base..base+len-1 and broadcasts each address to the three rect ROM readers.
// First address 1 cycle after command accept; advances only when all branches accept.
module feature_addr_gen
    import feature_addr_pkg::*;
#(
    parameter int W_ADDR = W_ADDR_DEF,
    parameter int W_CNT  = W_CNT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stage_valid,
    output logic              stage_ready,
    input  logic [W_ADDR-1:0] stage_base,
    input  logic [W_CNT-1:0]  stage_len,
    output logic              rect0_addr_valid,
    input  logic              rect0_addr_ready,
    output logic [W_ADDR-1:0] rect0_addr_data,
    output logic              rect1_addr_valid,
    input  logic              rect1_addr_ready,
    output logic [W_ADDR-1:0] rect1_addr_data,
    output logic              rect2_addr_valid,
    input  logic              rect2_addr_ready,
    output logic [W_ADDR-1:0] rect2_addr_data,
    output logic              feat_last,
    output logic              stage_done
);

    state_t                state_q, state_d;
    logic [W_ADDR-1:0]     base_q, base_d;
    logic [W_CNT-1:0]      len_q, len_d;
    logic [W_CNT-1:0]      cnt_q, cnt_d;
    logic [W_ADDR-1:0]     addr_q, addr_d;
    logic                  last_q, last_d;
    logic                  done_q, done_d;

    logic                                  all_accepted;
    logic [NUM_RECTS-1:0]                  br_vld;
    logic [NUM_RECTS-1:0]                  br_rdy;
    logic [NUM_RECTS-1:0][W_ADDR-1:0]      br_dat;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        last_d  = last_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (stage_valid) begin
                    if (stage_len != '0) begin
                        state_d = ISSUE;
                        base_d  = stage_base;
                        len_d   = stage_len;
                        cnt_d   = '0;
                        addr_d  = stage_base;
                        last_d  = (stage_len == W_CNT'(1));
                    end else begin
                        done_d  = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (all_accepted) begin
                    if (last_q) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + W_CNT'(1);
                        // Address arithmetic wraps modulo 2^W_ADDR by design.
                        addr_d  = base_q + W_ADDR'(cnt_d);
                        last_d  = (cnt_d == len_q - W_CNT'(1));
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    assign br_rdy = {rect2_addr_ready, rect1_addr_ready, rect0_addr_ready};

    addr_fork #(
        .NUM_BR (NUM_RECTS),
        .W_DAT  (W_ADDR)
    ) u_fork (
        .clk          (clk),
        .rst          (rst),
        .src_vld      (state_q == ISSUE),
        .src_dat      (addr_q),
        .br_vld       (br_vld),
        .br_rdy       (br_rdy),
        .br_dat       (br_dat),
        .all_accepted (all_accepted)
    );

    assign stage_ready      = (state_q == IDLE);
    assign stage_done       = done_q;
    assign feat_last        = last_q;
    assign rect0_addr_valid = br_vld[0];
    assign rect1_addr_valid = br_vld[1];
    assign rect2_addr_valid = br_vld[2];
    assign rect0_addr_data  = br_dat[0];
    assign rect1_addr_data  = br_dat[1];
    assign rect2_addr_data  = br_dat[2];

endmodule

// File: tb/tb_feature_addr_gen.sv
// Scoreboarded bench for feature_addr_gen: directed timing checks plus randomised ready traffic.
module tb_feature_addr_gen;

    localparam int W_ADDR = 14;
    localparam int W_CNT  = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              stage_valid;
    logic              stage_ready;
    logic [W_ADDR-1:0] stage_base;
    logic [W_CNT-1:0]  stage_len;
    logic [2:0]        vld;
    logic [2:0]        rdy;
    logic [W_ADDR-1:0] dat [3];
    logic              feat_last;
    logic              stage_done;

    int         checks = 0;
    int         errors = 0;
    int         rdy_mode;
    logic [2:0] rdy_man;
    logic [2:0] rnd = 3'b111;

    logic [W_ADDR:0] eq0[$];
    logic [W_ADDR:0] eq1[$];
    logic [W_ADDR:0] eq2[$];
    int              done_exp = 0;
    logic [2:0]      pv = '0;
    logic [2:0]      pr = '0;
    logic [W_ADDR:0] pd [3];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        rnd = 3'($urandom_range(0, 7));
    end

    assign rdy = (rdy_mode == 0) ? 3'b111 : (rdy_mode == 1) ? rnd : rdy_man;

    feature_addr_gen #(.W_ADDR(W_ADDR), .W_CNT(W_CNT)) dut (
        .clk              (clk),
        .rst              (rst),
        .stage_valid      (stage_valid),
        .stage_ready      (stage_ready),
        .stage_base       (stage_base),
        .stage_len        (stage_len),
        .rect0_addr_valid (vld[0]),
        .rect0_addr_ready (rdy[0]),
        .rect0_addr_data  (dat[0]),
        .rect1_addr_valid (vld[1]),
        .rect1_addr_ready (rdy[1]),
        .rect1_addr_data  (dat[1]),
        .rect2_addr_valid (vld[2]),
        .rect2_addr_ready (rdy[2]),
        .rect2_addr_data  (dat[2]),
        .feat_last        (feat_last),
        .stage_done       (stage_done)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Scoreboard: commands seen accepted push the expected address stream; branch fires pop it.
    always @(negedge clk) begin
        logic [W_ADDR:0]   obs;
        logic [W_ADDR:0]   e;
        logic [W_ADDR-1:0] a;
        bit                have;
        if (rst) begin
            eq0.delete();
            eq1.delete();
            eq2.delete();
            done_exp = 0;
            pv = '0;
        end else begin
            for (int n = 0; n < 3; n++) begin
                obs = {feat_last, dat[n]};
                if (pv[n] && !pr[n]) begin
                    check("hold_vld", 32'(vld[n]), 32'd1);
                    check("hold_dat", 32'(obs), 32'(pd[n]));
                end
                if (vld[n] && rdy[n]) begin
                    e = '0;
                    case (n)
                        0: have = (eq0.size() != 0);
                        1: have = (eq1.size() != 0);
                        default: have = (eq2.size() != 0);
                    endcase
                    check("addr_avail", 32'(have), 32'd1);
                    if (have) begin
                        case (n)
                            0: e = eq0.pop_front();
                            1: e = eq1.pop_front();
                            default: e = eq2.pop_front();
                        endcase
                        check("addr", 32'(obs), 32'(e));
                    end
                end
                pv[n] = vld[n];
                pr[n] = rdy[n];
                pd[n] = obs;
            end
            if (stage_done) begin
                check("done_expected", 32'(done_exp > 0), 32'd1);
                check("done_drained", 32'(eq0.size() + eq1.size() + eq2.size()), 32'd0);
                if (done_exp > 0) done_exp--;
            end
            if (stage_valid && stage_ready) begin
                for (int i = 0; i < int'(stage_len); i++) begin
                    a = stage_base + W_ADDR'(i);
                    e = {(i == int'(stage_len) - 1), a};
                    eq0.push_back(e);
                    eq1.push_back(e);
                    eq2.push_back(e);
                end
                done_exp++;
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_cmd(input logic [W_ADDR-1:0] base, input logic [W_CNT-1:0] len,
                            output int waits, output logic done_s, output logic [2:0] vld_s);
        waits       = 0;
        stage_valid = 1'b1;
        stage_base  = base;
        stage_len   = len;
        while (1) begin
            @(negedge clk);
            if (stage_ready || waits >= 200) break;
            waits++;
        end
        check("cmd_accept", 32'(stage_ready), 32'd1);
        done_s = stage_done;
        vld_s  = vld;
        @(posedge clk);
        #1;
        stage_valid = 1'b0;
    endtask

    initial begin
        int         w;
        logic       d;
        logic [2:0] v;
        int         guard;

        rst         = 1'b1;
        stage_valid = 1'b0;
        stage_base  = '0;
        stage_len   = '0;
        rdy_mode    = 0;
        rdy_man     = 3'b000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_vld", 32'(vld), 32'd0);
        check("rst_ready", 32'(stage_ready), 32'd1);
        check("rst_done", 32'(stage_done), 32'd0);
        check("rst_last", 32'(feat_last), 32'd0);
        check("rst_dat", 32'(dat[1]), 32'd0);
        sync();
        rst = 1'b0;
        sync();

        // Basic stage, all readys high
        send_cmd(14'd100, 10'd4, w, d, v);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("basic_vld", 32'(vld), 32'd7);
            check("basic_dat", 32'(dat[2]), 32'(100 + k));
            check("basic_last", 32'(feat_last), 32'(k == 3));
            check("basic_ready", 32'(stage_ready), 32'd0);
        end
        @(negedge clk);
        check("basic_done", 32'(stage_done), 32'd1);
        check("basic_vld_off", 32'(vld), 32'd0);
        check("basic_ready_back", 32'(stage_ready), 32'd1);
        @(negedge clk);
        check("basic_done_pulse", 32'(stage_done), 32'd0);
        sync();

        // Skewed readys: rect2 one cycle late, rect1 three cycles late
        rdy_mode = 2;
        rdy_man  = 3'b001;
        send_cmd(14'd5, 10'd2, w, d, v);
        @(negedge clk);
        check("skew_c1_vld", 32'(vld), 32'd7);
        check("skew_c1_dat", 32'(dat[1]), 32'd5);
        sync();
        rdy_man = 3'b101;
        @(negedge clk);
        check("skew_c2_vld", 32'(vld), 32'b110);
        check("skew_c2_dat", 32'(dat[2]), 32'd5);
        sync();
        rdy_man = 3'b001;
        @(negedge clk);
        check("skew_c3_vld", 32'(vld), 32'b010);
        check("skew_c3_dat", 32'(dat[1]), 32'd5);
        sync();
        rdy_man = 3'b111;
        @(negedge clk);
        check("skew_c4_vld", 32'(vld), 32'b010);
        check("skew_c4_last", 32'(feat_last), 32'd0);
        @(negedge clk);
        check("skew_c5_vld", 32'(vld), 32'd7);
        check("skew_c5_dat", 32'(dat[0]), 32'd6);
        check("skew_c5_last", 32'(feat_last), 32'd1);
        @(negedge clk);
        check("skew_done", 32'(stage_done), 32'd1);
        sync();
        rdy_mode = 0;

        // Zero length, then a command taken in the done cycle
        send_cmd(14'd7, 10'd0, w, d, v);
        send_cmd(14'd300, 10'd2, w, d, v);
        check("zero_wait", 32'(w), 32'd0);
        check("zero_done", 32'(d), 32'd1);
        check("zero_no_vld", 32'(v), 32'd0);
        @(negedge clk);
        check("zero_next_vld", 32'(vld), 32'd7);
        check("zero_next_dat", 32'(dat[0]), 32'd300);
        sync();
        sync();
        sync();

        // Back-to-back: second command waits for the done cycle
        send_cmd(14'd200, 10'd3, w, d, v);
        send_cmd(14'd400, 10'd2, w, d, v);
        check("b2b_wait", 32'(w), 32'd3);
        check("b2b_done", 32'(d), 32'd1);
        @(negedge clk);
        check("b2b_vld", 32'(vld), 32'd7);
        check("b2b_dat", 32'(dat[1]), 32'd400);
        sync();
        sync();
        sync();

        // Reset mid-stage during the third address
        send_cmd(14'd50, 10'd10, w, d, v);
        sync();
        sync();
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_dat", 32'(dat[0]), 32'd52);
        sync();
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_vld", 32'(vld), 32'd0);
        check("rstmid_ready", 32'(stage_ready), 32'd1);
        check("rstmid_done", 32'(stage_done), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rstmid_quiet", 32'({vld, stage_done}), 32'd0);
        end
        sync();
        send_cmd(14'd0, 10'd1, w, d, v);
        @(negedge clk);
        check("rstmid_new_vld", 32'(vld), 32'd7);
        check("rstmid_new_dat", 32'(dat[2]), 32'd0);
        check("rstmid_new_last", 32'(feat_last), 32'd1);
        @(negedge clk);
        check("rstmid_new_done", 32'(stage_done), 32'd1);
        sync();

        // Wrap-around and random stages under random readys
        rdy_mode = 1;
        send_cmd(14'd16382, 10'd4, w, d, v);
        for (int s = 0; s < 8; s++) begin
            send_cmd(14'($urandom), 10'($urandom_range(1, 6)), w, d, v);
        end
        guard = 0;
        while ((eq0.size() + eq1.size() + eq2.size() != 0 || done_exp != 0) && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check("drain_addr", 32'(eq0.size() + eq1.size() + eq2.size()), 32'd0);
        check("drain_done", 32'(done_exp), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
